// File: rtl/ysyx_040750_pipe_stage_buf.sv
// Elastic pipeline stage buffer: a small circular FIFO with exec-done gating on the head,
// a multicycle tag per entry, and a registered pulse when a tagged entry becomes head.
module ysyx_040750_pipe_stage_buf #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              I_sys_clk,
    input  logic              I_rst_n,
    input  logic              I_in_valid,
    output logic              O_in_allowin,
    input  logic [DATA_W-1:0] I_in_data,
    input  logic              I_exec_done,
    input  logic              I_multicycle,
    output logic              O_out_valid,
    input  logic              I_out_allowout,
    output logic [DATA_W-1:0] O_out_data,
    output logic              O_head_start,
    input  logic              I_flush,
    output logic [CNT_W-1:0]  O_count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              tag_q [DEPTH];
    logic              tag_d [DEPTH];
    logic [DEPTH-1:0]  wr_en;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  disp_ptr_q, disp_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              head_start_q, head_start_d;
    logic              push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign O_out_valid  = (count_q != '0) && I_exec_done;
    assign pop          = O_out_valid && I_out_allowout && !I_flush;
    // When full, a same-cycle pop frees the slot the push will land in.
    assign O_in_allowin = (count_q != FULL_CNT) || pop;
    assign push         = I_in_valid && O_in_allowin && !I_flush;

    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        head_start_d = 1'b0;
        if (I_flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            // New head is either the incoming entry (stage empty after this edge's pop)
            // or the second-oldest held entry.
            if (push && ((count_q == '0) || ((count_q == ONE_CNT) && pop)))
                head_start_d = I_multicycle;
            else if (pop && (count_q > ONE_CNT))
                head_start_d = tag_q[ptr_inc(rd_ptr_q)];
        end
        // Output slot freezes while empty so the last payload stays visible.
        disp_ptr_d = (count_d != '0) ? rd_ptr_d : disp_ptr_q;
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            disp_ptr_q   <= '0;
            head_start_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            disp_ptr_q   <= disp_ptr_d;
            head_start_q <= head_start_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
            assign mem_d[gi] = wr_en[gi] ? I_in_data : mem_q[gi];
            assign tag_d[gi] = wr_en[gi] ? I_multicycle : tag_q[gi];

            always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    mem_q[gi] <= '0;
                    tag_q[gi] <= 1'b0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                    tag_q[gi] <= tag_d[gi];
                end
            end
        end
    endgenerate

    assign O_out_data   = mem_q[disp_ptr_q];
    assign O_head_start = head_start_q;
    assign O_count      = count_q;

endmodule

// File: tb/tb_ysyx_040750_pipe_stage_buf.sv
// Scoreboard bench: a queue-level model predicts occupancy, head pulses and payload order;
// a negedge monitor compares the DUT. A second DEPTH=1 instance checks streaming throughput.
module tb_ysyx_040750_pipe_stage_buf;
    localparam int DW = 8;
    localparam int DP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          in_valid, multicycle, exec_done, allowout, flush;
    logic [DW-1:0] in_data;
    logic          allowin, out_valid, head_start;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    logic          v1, mc1, ed1, ao1, fl1;
    logic [DW-1:0] d1;
    logic          allowin1, out_valid1, head_start1;
    logic [DW-1:0] out_data1;
    logic          count1;

    ysyx_040750_pipe_stage_buf #(.DATA_W(DW), .DEPTH(DP)) dut (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_in_valid(in_valid), .O_in_allowin(allowin),
        .I_in_data(in_data), .I_exec_done(exec_done), .I_multicycle(multicycle),
        .O_out_valid(out_valid), .I_out_allowout(allowout), .O_out_data(out_data),
        .O_head_start(head_start), .I_flush(flush), .O_count(count)
    );

    ysyx_040750_pipe_stage_buf #(.DATA_W(DW), .DEPTH(1)) dut1 (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_in_valid(v1), .O_in_allowin(allowin1),
        .I_in_data(d1), .I_exec_done(ed1), .I_multicycle(mc1),
        .O_out_valid(out_valid1), .I_out_allowout(ao1), .O_out_data(out_data1),
        .O_head_start(head_start1), .I_flush(fl1), .O_count(count1)
    );

    typedef struct {logic tag; logic [DW-1:0] data;} ent_t;

    ent_t          model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_hs = 1'b0;
    logic [DW-1:0] m_disp = '0;
    logic [DW-1:0] q1[$];
    int            checks = 0, failures = 0;
    int            cyc = 0, rcv1 = 0, first1 = -1, last1 = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: acceptance and ordering derived from occupancy of a plain queue.
    always @(posedge clk or negedge rst_n) begin
        int   n;
        logic mp, mpu;
        if (!rst_n) begin
            model_q.delete();
            exp_q.delete();
            exp_hs = 1'b0;
            m_disp = '0;
        end else begin
            n   = model_q.size();
            mp  = (n > 0) && exec_done && allowout && !flush;
            mpu = in_valid && ((n < DP) || mp) && !flush;
            if (flush) begin
                model_q.delete();
                exp_q.delete();
                exp_hs = 1'b0;
            end else begin
                if (mpu && ((n == 0) || ((n == 1) && mp))) exp_hs = multicycle;
                else if (mp && (n >= 2))                   exp_hs = model_q[1].tag;
                else                                       exp_hs = 1'b0;
                if (mp) void'(model_q.pop_front());
                if (mpu) begin
                    model_q.push_back(ent_t'{tag: multicycle, data: in_data});
                    exp_q.push_back(in_data);
                end
            end
            if (model_q.size() > 0) m_disp = model_q[0].data;
        end
    end

    // Monitor for the DEPTH=2 instance.
    always @(negedge clk) begin
        int   n;
        logic ev;
        n  = model_q.size();
        ev = (n > 0) && exec_done;
        check("count", 32'(count), 32'(n));
        check("out_valid", 32'(out_valid), 32'(ev));
        check("allowin", 32'(allowin), 32'((n < DP) || (ev && allowout && !flush)));
        check("head_start", 32'(head_start), 32'(exp_hs));
        if (n == 0) check("hold_data", 32'(out_data), 32'(m_disp));
        else        check("head_data", 32'(out_data), 32'(model_q[0].data));
        if (out_valid && allowout && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
            end else begin
                check("out_order", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q1.delete();
        else if (v1) q1.push_back(d1);
    end

    // Monitor for the DEPTH=1 instance: with downstream always ready it never stalls.
    always @(negedge clk) begin
        check("d1_allowin", 32'(allowin1), 32'd1);
        if (out_valid1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d1_unexpected: got 0x%0h expected no output", out_data1);
            end else begin
                check("d1_order", 32'(out_data1), 32'(q1.pop_front()));
            end
            if (first1 < 0) first1 = cyc;
            last1 = cyc;
            rcv1++;
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic mc,
                         input logic ed, input logic ao, input logic fl);
        in_valid = v; in_data = d; multicycle = mc;
        exec_done = ed; allowout = ao; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 0; in_data = '0; multicycle = 0; exec_done = 0; allowout = 0; flush = 0;
        v1 = 0; d1 = '0; mc1 = 0; ed1 = 1; ao1 = 1; fl1 = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full while downstream stalls, then hold one cycle.
        drive(1, 8'h11, 0, 1, 0, 0);
        drive(1, 8'h22, 0, 1, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 0);
        // Full: same-cycle pop and push, then drain.
        drive(1, 8'h33, 0, 1, 1, 0);
        repeat (3) drive(0, 8'h00, 0, 1, 1, 0);

        // Multicycle entry waits on exec_done.
        drive(1, 8'h44, 1, 0, 1, 0);
        repeat (3) drive(0, 8'h00, 0, 0, 1, 0);
        repeat (2) drive(0, 8'h00, 0, 1, 1, 0);

        // Flush with a same-cycle push.
        drive(1, 8'h61, 0, 1, 0, 0);
        drive(1, 8'h62, 0, 1, 0, 0);
        drive(1, 8'h55, 0, 1, 0, 1);
        repeat (2) drive(0, 8'h00, 0, 1, 1, 0);

        // Asynchronous reset between edges while full.
        drive(1, 8'h71, 1, 1, 0, 0);
        drive(1, 8'h72, 1, 1, 0, 0);
        in_valid = 0;
        check("pre_reset_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_allowin", 32'(allowin), 32'd1);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 9) < 7), DW'($urandom), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) < 6),
                  logic'($urandom_range(0, 19) == 0));
        end
        repeat (6) drive(0, 8'h00, 0, 1, 1, 0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // DEPTH=1 streaming: four payloads on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1;
            d1 = DW'(8'hA1 + i);
            @(posedge clk);
            #1;
        end
        v1 = 1'b0;
        for (int i = 0; i < 8 && rcv1 < 4; i++) @(posedge clk);
        #1;
        check("d1_received", 32'(rcv1), 32'd4);
        check("d1_span", 32'(last1 - first1), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
